// File: rtl/code_matcher_if.sv
// code_matcher_if: keypad strobe, mode/code inputs and compare results of the code matcher
interface code_matcher_if #(
    parameter int DIGITS   = 6,
    parameter int DW       = 4,
    parameter int MAX_FAIL = 3
);
    localparam int W  = DIGITS * DW;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    logic          key_valid;
    logic [DW-1:0] key;
    logic [1:0]    mode;
    logic [W-1:0]  master_code;
    logic [W-1:0]  user_code;
    logic          match;
    logic          mismatch;
    logic          enroll_done;
    logic [W-1:0]  new_code;
    logic          locked;
    logic [CW-1:0] entry_count;
    logic [FW-1:0] fail_count;
    modport master (
        output key_valid, key, mode, master_code, user_code,
        input  match, mismatch, enroll_done, new_code, locked, entry_count, fail_count
    );
    modport slave (
        input  key_valid, key, mode, master_code, user_code,
        output match, mismatch, enroll_done, new_code, locked, entry_count, fail_count
    );
endinterface

// File: rtl/code_matcher.sv
// code_matcher: keypad entry buffer with master/user/enroll compare, failure counting and timed lockout
module code_matcher #(
    parameter int DIGITS      = 6,
    parameter int DW          = 4,
    parameter int WILD_LEAD   = 2,
    parameter int ENTER_KEY   = 10,
    parameter int CLEAR_KEY   = 11,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 12000000
) (
    input logic           hwclk,
    input logic           rst_n,
    code_matcher_if.slave bus
);
    localparam int W  = DIGITS * DW;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [DW-1:0] K_ENTER   = DW'(ENTER_KEY);
    localparam logic [DW-1:0] K_CLEAR   = DW'(CLEAR_KEY);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DIGITS);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {S_ENTRY, S_CONFIRM, S_LOCK} state_t;

    state_t        state, state_n;
    logic [W-1:0]  ent, ent_n;
    logic [W-1:0]  cap, cap_n;
    logic [W-1:0]  code, code_n;
    logic [CW-1:0] ecnt, ecnt_n;
    logic [FW-1:0] fail, fail_n;
    logic [LW-1:0] lock_cnt, lock_n;
    logic          match_r, match_n;
    logic          mism_r, mism_n;
    logic          enr_r, enr_n;
    logic          master_ok, user_ok, enroll_ok, cmp_ok;

    // digit 0 sits in the MSBs; the leading `wild` stored digits accept anything when zero
    function automatic logic code_eq(input logic [W-1:0] entry, input logic [W-1:0] stored, input int wild);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (entry[(DIGITS-1-i)*DW +: DW] != stored[(DIGITS-1-i)*DW +: DW] &&
                !(i < wild && stored[(DIGITS-1-i)*DW +: DW] == '0))
                ok = 1'b0;
        return ok;
    endfunction

    assign master_ok = code_eq(ent, bus.master_code, 0);
    assign user_ok   = code_eq(ent, bus.user_code, WILD_LEAD);
    assign enroll_ok = code_eq(ent, cap, WILD_LEAD);
    assign cmp_ok    = bus.mode == 2'b00 ? master_ok : user_ok;

    assign bus.match       = match_r;
    assign bus.mismatch    = mism_r;
    assign bus.enroll_done = enr_r;
    assign bus.new_code    = code;
    assign bus.locked      = state == S_LOCK;
    assign bus.entry_count = ecnt;
    assign bus.fail_count  = fail;

    // register every piece of state; reset drops everything including any pending pulse
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_ENTRY;
            ent      <= '0;
            cap      <= '0;
            code     <= '0;
            ecnt     <= '0;
            fail     <= '0;
            lock_cnt <= '0;
            match_r  <= 1'b0;
            mism_r   <= 1'b0;
            enr_r    <= 1'b0;
        end else begin
            state    <= state_n;
            ent      <= ent_n;
            cap      <= cap_n;
            code     <= code_n;
            ecnt     <= ecnt_n;
            fail     <= fail_n;
            lock_cnt <= lock_n;
            match_r  <= match_n;
            mism_r   <= mism_n;
            enr_r    <= enr_n;
        end
    end

    // key handling, compare evaluation, enroll sequencing and lockout countdown
    always_comb begin
        state_n = state;
        ent_n   = ent;
        cap_n   = cap;
        code_n  = code;
        ecnt_n  = ecnt;
        fail_n  = fail;
        lock_n  = lock_cnt;
        match_n = 1'b0;
        mism_n  = 1'b0;
        enr_n   = 1'b0;
        if (state == S_LOCK) begin
            state_n = lock_cnt == '0 ? S_ENTRY : S_LOCK;
            fail_n  = lock_cnt == '0 ? '0 : fail;
            lock_n  = lock_cnt == '0 ? lock_cnt : lock_cnt - LW'(1);
        end else begin
            if (state == S_CONFIRM && bus.mode != 2'b10) begin
                state_n = S_ENTRY;
                cap_n   = '0;
            end
            if (bus.key_valid && bus.key == K_CLEAR) begin
                ent_n  = '0;
                ecnt_n = '0;
                if (state == S_CONFIRM) begin
                    state_n = S_ENTRY;
                    cap_n   = '0;
                end
            end else if (bus.key_valid && bus.key == K_ENTER) begin
                ent_n  = '0;
                ecnt_n = '0;
                if (!bus.mode[1]) begin
                    match_n = cmp_ok;
                    mism_n  = !cmp_ok;
                    fail_n  = cmp_ok ? '0 : (fail == FAIL_MAX ? fail : fail + FW'(1));
                    if (!cmp_ok && fail >= FAIL_LAST) begin
                        state_n = S_LOCK;
                        lock_n  = LOCK_LOAD;
                    end
                end else if (bus.mode == 2'b10 && state == S_ENTRY) begin
                    cap_n   = ent;
                    state_n = S_CONFIRM;
                end else if (bus.mode == 2'b10) begin
                    match_n = enroll_ok;
                    mism_n  = !enroll_ok;
                    enr_n   = enroll_ok;
                    code_n  = enroll_ok ? cap : code;
                    cap_n   = '0;
                    state_n = S_ENTRY;
                end
            end else if (bus.key_valid) begin
                ent_n  = W'({ent, bus.key});
                ecnt_n = ecnt == CNT_FULL ? ecnt : ecnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_code_matcher.sv
// tb_code_matcher: directed scoreboard bench for code_matcher
module tb_code_matcher;
    localparam int LC = 20;
    localparam logic [3:0] ENT = 4'd10;
    localparam logic [3:0] CLR = 4'd11;

    logic hwclk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];

    code_matcher_if #(.DIGITS(6), .DW(4), .MAX_FAIL(3)) bus();
    code_matcher #(.LOCK_CYCLES(LC)) dut (.hwclk(hwclk), .rst_n(rst_n), .bus(bus));

    always #5 hwclk = ~hwclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge hwclk);
        bus.key_valid = 1'b1;
        bus.key = k;
        @(negedge hwclk);
        bus.key_valid = 1'b0;
    endtask

    task automatic keys(input logic [31:0] digits, input int n);
        for (int i = n - 1; i >= 0; i--) press(digits[i*4 +: 4]);
    endtask

    task automatic enter(input string tag, input logic [2:0] e);
        exp_q.push_back(e);
        press(ENT);
        chk(tag, {29'd0, bus.match, bus.mismatch, bus.enroll_done}, {29'd0, exp_q.pop_front()});
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key = '0;
        bus.mode = 2'b00;
        bus.master_code = 24'h123456;
        bus.user_code = 24'h003579;
        repeat (2) @(negedge hwclk);
        chk("rst_pulses", {28'd0, bus.match, bus.mismatch, bus.enroll_done, bus.locked}, 0);
        chk("rst_new_code", bus.new_code, 0);
        chk("rst_fail", bus.fail_count, 0);
        chk("rst_count", bus.entry_count, 0);
        rst_n = 1'b1;
        keys(32'h123456, 6);
        chk("count_full", bus.entry_count, 6);
        enter("master_ok", 3'b100);
        chk("master_fail", bus.fail_count, 0);
        chk("master_count", bus.entry_count, 0);
        @(negedge hwclk);
        chk("pulse_len", {29'd0, bus.match, bus.mismatch, bus.enroll_done}, 0);
        bus.mode = 2'b01;
        keys(32'h993579, 6);
        enter("user_wild", 3'b100);
        keys(32'h3579, 4);
        enter("user_short", 3'b100);
        keys(32'h3578, 4);
        enter("user_bad", 3'b010);
        chk("user_fail", bus.fail_count, 1);
        bus.mode = 2'b00;
        keys(32'h123456, 6);
        enter("master_clr_fail", 3'b100);
        chk("fail_cleared", bus.fail_count, 0);
        keys(32'h1, 1);
        enter("wrong1", 3'b010);
        chk("wrong1_fail", bus.fail_count, 1);
        chk("wrong1_lock", bus.locked, 0);
        keys(32'h2, 1);
        enter("wrong2", 3'b010);
        chk("wrong2_fail", bus.fail_count, 2);
        keys(32'h3, 1);
        enter("wrong3", 3'b010);
        chk("lock_rise", bus.locked, 1);
        chk("lock_fail_sat", bus.fail_count, 3);
        for (int i = 1; i < LC; i++) begin
            @(negedge hwclk);
            chk("lock_hold", bus.locked, 1);
            chk("lock_count", bus.entry_count, 0);
            bus.key_valid = 1'b1;
            bus.key = (i % 3 == 0) ? CLR : 4'd5;
        end
        @(negedge hwclk);
        bus.key_valid = 1'b0;
        chk("lock_fall", bus.locked, 0);
        chk("lock_fail_clr", bus.fail_count, 0);
        chk("lock_keys_dropped", bus.entry_count, 0);
        keys(32'h123456, 6);
        enter("after_lock", 3'b100);
        keys(32'h1, 1);
        enter("pre_enroll_bad", 3'b010);
        bus.mode = 2'b10;
        keys(32'h441122, 6);
        enter("enroll_first", 3'b000);
        keys(32'h441122, 6);
        enter("enroll_ok", 3'b101);
        chk("enroll_code", bus.new_code, 24'h441122);
        chk("enroll_fail_keep", bus.fail_count, 1);
        keys(32'h441122, 6);
        enter("enroll_first2", 3'b000);
        keys(32'h441123, 6);
        enter("enroll_bad", 3'b010);
        chk("enroll_code_keep", bus.new_code, 24'h441122);
        chk("enroll_bad_fail", bus.fail_count, 1);
        bus.mode = 2'b00;
        bus.master_code = 24'h000000;
        keys(32'h123, 3);
        press(CLR);
        chk("clear_count", bus.entry_count, 0);
        enter("clear_zero", 3'b100);
        chk("clear_fail", bus.fail_count, 0);
        bus.master_code = 24'h234567;
        keys(32'h1234567, 7);
        chk("count_sat", bus.entry_count, 6);
        enter("overflow_drop", 3'b100);
        bus.mode = 2'b11;
        keys(32'h12, 2);
        enter("idle_enter", 3'b000);
        chk("idle_count", bus.entry_count, 0);
        bus.mode = 2'b00;
        bus.master_code = 24'h123456;
        keys(32'h9, 1);
        enter("pre_rst1", 3'b010);
        keys(32'h9, 1);
        enter("pre_rst2", 3'b010);
        chk("pre_rst_fail", bus.fail_count, 2);
        bus.mode = 2'b10;
        keys(32'h7, 1);
        enter("pre_rst_cap", 3'b000);
        @(negedge hwclk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pulses", {28'd0, bus.match, bus.mismatch, bus.enroll_done, bus.locked}, 0);
        chk("mid_rst_fail", bus.fail_count, 0);
        chk("mid_rst_code", bus.new_code, 0);
        @(negedge hwclk);
        rst_n = 1'b1;
        enter("post_rst_enroll", 3'b000);
        chk("post_rst_fail", bus.fail_count, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/code_matcher.md
# code_matcher

Parametrised, fully synchronous keypad code checker for the digital-lock datapath. It buffers a stream of key strobes into an N-digit entry register and compares the entry against the master code, the stored user code, or a second confirming entry. It counts consecutive failures, enforces a timed lockout, and publishes a newly enrolled user code. It sits between the keypad debouncer/decoder and the lock control FSM.

## Interface
Parameters:
- DIGITS, 6, number of digits in a code
- DW, 4, bits per digit/key value
- WILD_LEAD, 2, count of most-significant digits where a stored 0 matches any entered digit (user-code and enroll compares only)
- ENTER_KEY, 10, key value that triggers evaluation
- CLEAR_KEY, 11, key value that discards the current entry
- MAX_FAIL, 3, consecutive mismatches that trigger lockout (≥1)
- LOCK_CYCLES, 12000000, lockout duration in hwclk cycles (≥1)

Ports:
- hwclk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle strobe, key is valid
- key  in  DW  decoded key value
- mode  in  2  00 master compare, 01 user compare, 10 enroll, 11 idle (ENTER ignored)
- master_code  in  DIGITS*DW  master code, digit 0 (first entered) in MSBs
- user_code  in  DIGITS*DW  current user code, same packing
- match  out  1  one-cycle pulse, compare succeeded
- mismatch  out  1  one-cycle pulse, compare failed
- enroll_done  out  1  one-cycle pulse, new_code updated
- new_code  out  DIGITS*DW  last enrolled code
- locked  out  1  level, lockout active
- entry_count  out  clog2(DIGITS+1)  digits held, saturates at DIGITS
- fail_count  out  clog2(MAX_FAIL+1)  consecutive failures

## Operation
- Entry buffer: DIGITS×DW, reset to all zeros. Digit key (not ENTER/CLEAR) shifts left one digit; new key enters LSB digit; oldest is dropped once full. Short entries are therefore left-padded with zeros.
- CLEAR_KEY: zero the buffer and entry_count. No pulse. In ENROLL_CONFIRM, also return to ENTRY.
- ENTER_KEY: evaluate per the mode sampled in the same cycle. Buffer and entry_count always zero afterwards.
- States:
  - ENTRY (reset state).
  - ENROLL_CONFIRM: first enroll entry held in a capture register.
  - LOCKOUT: all keys ignored; locked=1.
- Mode 00: exact compare to master_code. Match: match pulse, fail_count←0. Else: mismatch pulse, fail_count+1.
- Mode 01: compare to user_code. Digit i<WILD_LEAD matches if equal or stored digit==0. Other digits exact. Fail handling as mode 00.
- Mode 10:
  - In ENTRY: capture the buffer and go to ENROLL_CONFIRM. No pulse.
  - In ENROLL_CONFIRM: compare to the capture, with the same wildcard rule applied to the capture. Match: new_code←capture, enroll_done and match pulse. Else: mismatch pulse, fail_count unchanged. Either way go to ENTRY.
- Mode 11: ENTER only clears the buffer.
- mode differing from 10 while in ENROLL_CONFIRM: drop to ENTRY next cycle; capture zeroed.
- Failure reaching MAX_FAIL: enter LOCKOUT and load the lock counter with LOCK_CYCLES-1. Counter decrements each cycle. Leave at 0 → ENTRY with fail_count←0.
- fail_count saturates at MAX_FAIL and never wraps.

## Timing
- Reset values: match, mismatch, enroll_done, locked = 0. new_code, fail_count, entry_count, buffer, capture, lock counter = 0. State = ENTRY.
- Key handling: key registered at the key_valid cycle edge. entry_count and buffer update at that same edge.
- Compare latency: 1 cycle. The pulse is high for exactly the cycle after the ENTER strobe edge.
- new_code changes at the same edge enroll_done rises.
- locked rises at the same edge as the mismatch pulse that causes lockout. Exactly LOCK_CYCLES cycles later it falls.
- A key_valid during a pulse cycle is processed normally. Strobes on consecutive cycles are all accepted.
- key_valid during LOCKOUT is dropped, including CLEAR.
- rst_n asserted mid-entry or mid-lockout: all state returns to reset values immediately, with no pulse.
- Mode changes take effect only at ENTER, except the ENROLL_CONFIRM abort rule.

## Test plan
- Defaults; master_code=0x123456; keys 1,2,3,4,5,6,ENTER. Expected: match one cycle after ENTER, fail_count=0, entry_count=0.
- user_code=0x003579, mode 01; keys 9,9,3,5,7,9,ENTER then 3,5,7,9,ENTER. Expected: both match (leading-zero wildcard). Keys 3,5,7,8,ENTER → mismatch, fail_count=1.
- LOCK_CYCLES=20; three wrong master entries. Expected: locked rises with the 3rd mismatch; keys ignored for 20 cycles; locked=0 and fail_count=0 afterwards; correct entry → match.
- Mode 10; keys 4,4,1,1,2,2,ENTER twice. Expected: enroll_done and match on the 2nd ENTER; new_code=0x441122. Second entry 441123 → mismatch, new_code unchanged, fail_count unchanged.
- Keys 1,2,3,CLEAR,ENTER in mode 00 with master_code=0. Expected: match (all-zero buffer). Seven digits 1..7 then ENTER → buffer 0x234567.
- rst_n low for 1 cycle while in ENROLL_CONFIRM with fail_count=2. Expected: state ENTRY, all outputs 0, then a single mode-10 ENTER produces no pulse.
